sa_addr_filter: RTL

//  Receive-side destination-address filter; consumes the 64-bit station-address word from the station

---
 rtl/sa_pkg.sv | 34 +++
 rtl/sa_addr_filter.sv | 118 +++++++++++
 2 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared constants, state encoding and verdict helper for the address filter
package sa_pkg;

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_UCAST = 2'b01;
  localparam logic [1:0] KIND_BCAST = 2'b10;
  localparam logic [1:0] KIND_MCAST = 2'b11;

  localparam logic [7:0] BCAST_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_WAIT    = 2'd2
  } state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] kind;
  } verdict_t;

  // Kind follows broadcast > unicast > multicast; acceptance also honours promisc/allmulti.
  function automatic verdict_t judge(input logic uc_ok, input logic bc_ok, input logic mc,
                                     input logic promisc, input logic allmulti);
    verdict_t v;
    v.hit = bc_ok | uc_ok | (mc & (allmulti | promisc)) | promisc;
    if (bc_ok)      v.kind = KIND_BCAST;
    else if (uc_ok) v.kind = KIND_UCAST;
    else if (mc)    v.kind = KIND_MCAST;
    else            v.kind = KIND_NONE;
    return v;
  endfunction

endpackage

// File: rtl/sa_addr_filter.sv
// rtl/sa_addr_filter.sv - receive destination-address filter with one-shot accept/reject verdict
module sa_addr_filter
  import sa_pkg::*;
#(
  parameter int SA_BYTES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] sa_word,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic [7:0]  rx_data,
  input  logic        rx_abort,
  input  logic        promisc,
  input  logic        allmulti,
  output logic        busy,
  output logic        match_valid,
  output logic        match_hit,
  output logic [1:0]  match_kind
);

  localparam int CW = $clog2(SA_BYTES + 1);
  localparam int AW = 8 * SA_BYTES;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] sa_q, sa_d;
  logic          uc_ok_q, uc_ok_d;
  logic          bc_ok_q, bc_ok_d;
  logic          mc_q, mc_d;
  logic          valid_q, valid_d;
  logic          hit_q, hit_d;
  logic [1:0]    kind_q, kind_d;

  logic [7:0]    sa_byte;
  logic          done;
  verdict_t      verdict;

  // Address byte expected at the current position of the frame.
  always_comb begin
    sa_byte = '0;
    for (int k = 0; k < SA_BYTES; k++) begin
      if (cnt_q == CW'(k)) sa_byte = sa_q[8*k +: 8];
    end
  end

  // Next-state: abort beats sof, sof restarts from any state, COMPARE walks the address bytes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    uc_ok_d = uc_ok_q;
    bc_ok_d = bc_ok_q;
    mc_d    = mc_q;
    valid_d = 1'b0;
    hit_d   = hit_q;
    kind_d  = kind_q;
    done    = 1'b0;

    if (rx_abort) begin
      state_d = ST_IDLE;
    end else if (rx_valid && rx_sof) begin
      sa_d    = sa_word[AW-1:0];
      cnt_d   = CW'(1);
      uc_ok_d = (rx_data == sa_word[7:0]);
      bc_ok_d = (rx_data == BCAST_BYTE);
      mc_d    = rx_data[0];
      hit_d   = 1'b0;
      kind_d  = KIND_NONE;
      state_d = ST_COMPARE;
      done    = (SA_BYTES == 1);
    end else if (rx_valid && state_q == ST_COMPARE) begin
      uc_ok_d = uc_ok_q & (rx_data == sa_byte);
      bc_ok_d = bc_ok_q & (rx_data == BCAST_BYTE);
      cnt_d   = cnt_q + CW'(1);
      done    = (cnt_q == CW'(SA_BYTES - 1));
    end

    verdict = judge(uc_ok_d, bc_ok_d, mc_d, promisc, allmulti);
    if (done) begin
      valid_d = 1'b1;
      hit_d   = verdict.hit;
      kind_d  = verdict.kind;
      state_d = ST_WAIT;
    end
  end

  // State, flags and verdict registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      uc_ok_q <= 1'b0;
      bc_ok_q <= 1'b0;
      mc_q    <= 1'b0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      kind_q  <= KIND_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      uc_ok_q <= uc_ok_d;
      bc_ok_q <= bc_ok_d;
      mc_q    <= mc_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      kind_q  <= kind_d;
    end
  end

  assign busy        = (state_q == ST_COMPARE);
  assign match_valid = valid_q;
  assign match_hit   = hit_q;
  assign match_kind  = kind_q;

endmodule
